config_controller: RTL

Session controller for the healthcare system's configuration path. It authenticates an operator request against a fixed access key and collects the P and Q set-points as two separately confirmed entries. It then commits both to the monitoring datapath in a single cycle. Timeout, abort, range-error and brute-force lockout are handled so that a partial or unauthenticated configuration never reaches `dataP`/`dataQ`.

---
 rtl/config_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/config_controller.sv
// Configuration session controller: key authentication, two-step P/Q entry,
// atomic commit, with timeout, abort, range-error and brute-force lockout.
module config_controller #(
    parameter logic [7:0]  KEY_VALUE      = 8'b11000000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [6:0]  P_DEFAULT      = 7'd0,
    parameter logic [6:0]  Q_DEFAULT      = 7'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       request,
    input  logic       confirm,
    input  logic [7:0] key,
    input  logic [7:0] inputData,
    output logic [6:0] dataP,
    output logic [6:0] dataQ,
    output logic       busy,
    output logic       cfg_valid,
    output logic       err,
    output logic       locked
);

    localparam int unsigned FAIL_W  = 3;
    localparam int unsigned TMO_W   = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_P = 3'd1;
    localparam logic [2:0] LOAD_Q = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] LOCKED = 3'd4;

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAILS);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              req_q;
    logic              conf_q;
    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_next;
    logic [FAIL_W-1:0] fail_inc;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [6:0]        shadow_p;
    logic              req_rise;
    logic              conf_rise;
    logic              in_load;
    logic              err_next;
    logic              cap_p;
    logic              cap_q;

    assign req_rise  = request & ~req_q;
    assign conf_rise = confirm & ~conf_q;
    assign in_load   = (state == LOAD_P) || (state == LOAD_Q);
    assign fail_inc  = FAIL_W'(fail_cnt + FAIL_W'(1));

    // Next-state and per-cycle actions; abort beats confirm beats timeout.
    always_comb begin
        state_next = state;
        fail_next  = fail_cnt;
        err_next   = 1'b0;
        cap_p      = 1'b0;
        cap_q      = 1'b0;
        case (state)
            IDLE: begin
                if (req_rise) begin
                    if (key == KEY_VALUE) begin
                        fail_next  = '0;
                        state_next = LOAD_P;
                    end else begin
                        err_next  = 1'b1;
                        fail_next = fail_inc;
                        if (fail_inc == FAIL_LIM) begin
                            state_next = LOCKED;
                        end
                    end
                end
            end
            LOAD_P, LOAD_Q: begin
                if (!request) begin
                    state_next = IDLE;
                end else if (conf_rise) begin
                    if (inputData[7]) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (state == LOAD_P) begin
                        cap_p      = 1'b1;
                        state_next = LOAD_Q;
                    end else begin
                        cap_q      = 1'b1;
                        state_next = COMMIT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            COMMIT:  state_next = IDLE;
            LOCKED:  state_next = LOCKED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            conf_q    <= 1'b0;
            fail_cnt  <= '0;
            tmo_cnt   <= '0;
            shadow_p  <= '0;
            dataP     <= P_DEFAULT;
            dataQ     <= Q_DEFAULT;
            busy      <= 1'b0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state    <= state_next;
            req_q    <= request;
            conf_q   <= confirm;
            fail_cnt <= fail_next;
            // Counter restarts whenever an entry state is (re)entered.
            if (in_load && (state_next == state)) begin
                tmo_cnt <= TMO_W'(tmo_cnt + TMO_W'(1));
            end else begin
                tmo_cnt <= '0;
            end
            if (cap_p) begin
                shadow_p <= inputData[6:0];
            end
            // Both set-points are published together, only on commit.
            if (cap_q) begin
                dataP <= shadow_p;
                dataQ <= inputData[6:0];
            end
            busy      <= (state_next == LOAD_P) || (state_next == LOAD_Q) ||
                         (state_next == COMMIT);
            cfg_valid <= (state_next == COMMIT);
            err       <= err_next;
            locked    <= (state_next == LOCKED);
        end
    end

endmodule
